aoi_toggle_array: RTL and testbench

Parametrised, registered array of AND-OR-INVERT cells with per-channel output-toggle counters, used as a switching-activity source and monitor in power characterisation runs. Each channel evaluates a configurable AOI (or OAI, by mode) function. The result is captured into an output flop on an enable. Each output transition is counted in a saturating counter, and a four-phase request/acknowledge port reads the counters out.

---
 rtl/aoi_toggle_array.sv | 144 ++++++++++++++
 tb/tb_aoi_toggle_array.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/aoi_toggle_array.sv
// aoi_toggle_array
//   Registered array of AND-OR-INVERT / OR-AND-INVERT cells with one
//   saturating toggle counter per channel and a four-phase readout port.
//
//   Parameters: CH channels, GROUPS groups per channel, GW inputs per group,
//   CNTW counter width. W = GROUPS*GW+1 inputs per channel, SW = select width.
//
//   Ports:
//     CLK      clock, rising edge
//     RSTB     async active-low reset
//     EN       capture enable for QN (also gates toggle counting)
//     MODE     0 = AOI, 1 = OAI
//     IN       channel c uses IN[c*W +: W]
//     CLR      synchronous clear of all toggle counters
//     QN       registered cell outputs
//     RD_REQ   readout request (level, four-phase)
//     RD_SEL   channel to read (>= CH reads as 0)
//     RD_ACK   readout acknowledge
//     RD_DATA  counter snapshot taken when the request was accepted

// One channel: cell function, output flop and saturating toggle counter.
module aoi_toggle_lane #(
  parameter int GROUPS = 2,
  parameter int GW     = 2,
  parameter int CNTW   = 16,
  localparam int W     = GROUPS*GW+1
) (
  input  logic            gclk,
  input  logic            grst_n,
  input  logic            en,
  input  logic            mode,
  input  logic            clr,
  input  logic [W-1:0]    s,
  output logic            qn,
  output logic [CNTW-1:0] cnt
);

  logic and_any, or_all, f;

  always_comb begin
    and_any = 1'b0;
    or_all  = 1'b1;
    for (int g = 0; g < GROUPS; g++) begin
      and_any = and_any | (&s[g*GW +: GW]);
      or_all  = or_all  & (|s[g*GW +: GW]);
    end
    f = mode ? ~(or_all & s[W-1]) : ~(and_any | s[W-1]);
  end

  // Reset value 1 matches the AOI output for all-zero inputs.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      qn  <= 1'b1;
      cnt <= '0;
    end else begin
      if (en) qn <= f;
      // Clear has priority over a coincident toggle; counter sticks at all-ones.
      if (clr)
        cnt <= '0;
      else if (en && (f != qn) && !(&cnt))
        cnt <= cnt + 1'b1;
    end
  end

endmodule

module aoi_toggle_array #(
  parameter int  CH     = 4,
  parameter int  GROUPS = 2,
  parameter int  GW     = 2,
  parameter int  CNTW   = 16,
  localparam int W      = GROUPS*GW+1,
  localparam int SW     = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic            CLK,
  input  logic            RSTB,
  input  logic            EN,
  input  logic            MODE,
  input  logic [CH*W-1:0] IN,
  input  logic            CLR,
  output logic [CH-1:0]   QN,
  input  logic            RD_REQ,
  input  logic [SW-1:0]   RD_SEL,
  output logic            RD_ACK,
  output logic [CNTW-1:0] RD_DATA
);

  logic [CH-1:0][CNTW-1:0] cnt;

  // IN and cnt are split across the instance array one channel per lane.
  aoi_toggle_lane #(
    .GROUPS (GROUPS),
    .GW     (GW),
    .CNTW   (CNTW)
  ) u_lane [CH-1:0] (
    .gclk   (CLK),
    .grst_n (RSTB),
    .en     (EN),
    .mode   (MODE),
    .clr    (CLR),
    .s      (IN),
    .qn     (QN),
    .cnt    (cnt)
  );

  // Out-of-range selects match no lane and read as zero.
  logic [CNTW-1:0] sel_cnt;
  always_comb begin
    sel_cnt = '0;
    for (int i = 0; i < CH; i++)
      if (RD_SEL == SW'(i)) sel_cnt = cnt[i];
  end

  typedef enum logic {IDLE, ACK} rd_state_t;
  rd_state_t state, nxt;
  logic      load;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt  = state;
    load = 1'b0;
    case (state)
      IDLE: if (RD_REQ) begin
        nxt  = ACK;
        load = 1'b1;
      end
      ACK:  if (!RD_REQ) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Snapshot uses the pre-edge counter value; it holds through ACK and IDLE.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)     RD_DATA <= '0;
    else if (load) RD_DATA <= sel_cnt;
  end

  assign RD_ACK = (state == ACK);

endmodule

// File: tb/tb_aoi_toggle_array.sv
module tb_aoi_toggle_array;
  localparam int CH = 4, GROUPS = 2, GW = 2, CNTW = 4;
  localparam int W = GROUPS*GW+1;
  localparam int MAXC = (1 << CNTW) - 1;

  logic            CLK = 0;
  logic            RSTB;
  logic            EN = 0, MODE = 0, CLR = 0;
  logic [CH*W-1:0] IN = '0;
  logic [CH-1:0]   QN;
  logic            RD_REQ = 0;
  logic [1:0]      RD_SEL = '0;
  logic            RD_ACK;
  logic [CNTW-1:0] RD_DATA;
  // Second instance with CH=3 shares IN[14:0]/EN/MODE/CLR so its counters
  // equal channels 0..2 of the main one; it exercises out-of-range selects.
  logic [2:0]      QN2;
  logic            RD_REQ2 = 0;
  logic [1:0]      RD_SEL2 = '0;
  logic            RD_ACK2;
  logic [CNTW-1:0] RD_DATA2;

  int total = 0, bad = 0;

  always #5 CLK = ~CLK;

  aoi_toggle_array #(.CH(CH), .GROUPS(GROUPS), .GW(GW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .MODE(MODE), .IN(IN), .CLR(CLR), .QN(QN),
    .RD_REQ(RD_REQ), .RD_SEL(RD_SEL), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA));

  aoi_toggle_array #(.CH(3), .GROUPS(GROUPS), .GW(GW), .CNTW(CNTW)) dut2 (
    .CLK(CLK), .RSTB(RSTB), .EN(EN), .MODE(MODE), .IN(IN[3*W-1:0]), .CLR(CLR), .QN(QN2),
    .RD_REQ(RD_REQ2), .RD_SEL(RD_SEL2), .RD_ACK(RD_ACK2), .RD_DATA(RD_DATA2));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Cell function from the rules: count ones per group.
  function automatic logic fm(input logic [W-1:0] s, input logic m);
    int  ones;
    bit  any_full = 0, all_nonzero = 1;
    for (int g = 0; g < GROUPS; g++) begin
      ones = 0;
      for (int b = 0; b < GW; b++) ones += int'(s[g*GW+b]);
      if (ones == GW) any_full = 1;
      if (ones == 0)  all_nonzero = 0;
    end
    return m ? !(all_nonzero && s[W-1]) : !(any_full || s[W-1]);
  endfunction

  // Model state
  logic [CH-1:0]   qn_m = '1;
  int              cnt_m [CH];
  logic            ack_m = 0, ack2_m = 0;
  logic [CNTW-1:0] data_m = '0, data2_m = '0;

  always @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      qn_m <= '1;
      for (int c = 0; c < CH; c++) cnt_m[c] <= 0;
      ack_m <= 0; data_m <= '0; ack2_m <= 0; data2_m <= '0;
    end else begin
      if (!ack_m) begin
        if (RD_REQ) begin data_m <= CNTW'(cnt_m[RD_SEL]); ack_m <= 1; end
      end else if (!RD_REQ) ack_m <= 0;
      if (!ack2_m) begin
        if (RD_REQ2) begin data2_m <= (RD_SEL2 < 3) ? CNTW'(cnt_m[RD_SEL2]) : '0; ack2_m <= 1; end
      end else if (!RD_REQ2) ack2_m <= 0;
      for (int c = 0; c < CH; c++) begin
        if (EN) qn_m[c] <= fm(IN[c*W +: W], MODE);
        if (CLR) cnt_m[c] <= 0;
        else if (EN && fm(IN[c*W +: W], MODE) != qn_m[c] && cnt_m[c] < MAXC)
          cnt_m[c] <= cnt_m[c] + 1;
      end
    end
  end

  always @(negedge CLK) begin
    chk("qn", 32'(QN), 32'(qn_m));
    chk("ack", 32'(RD_ACK), 32'(ack_m));
    chk("rd_data", 32'(RD_DATA), 32'(data_m));
    chk("qn2", 32'(QN2), 32'(qn_m[2:0]));
    chk("ack2", 32'(RD_ACK2), 32'(ack2_m));
    chk("rd_data2", 32'(RD_DATA2), 32'(data2_m));
  end

  // Full four-phase read; all drives happen just after a falling edge.
  task automatic rd(input int which, input int sel, output logic [CNTW-1:0] d);
    int n;
    if (which == 0) begin RD_SEL = 2'(sel); RD_REQ = 1; end
    else            begin RD_SEL2 = 2'(sel); RD_REQ2 = 1; end
    n = 0;
    do begin @(negedge CLK); n++; end
    while (((which == 0) ? RD_ACK : RD_ACK2) !== 1'b1 && n < 20);
    if (n >= 20) chk("ack_rise_timeout", 0, 1);
    d = (which == 0) ? RD_DATA : RD_DATA2;
    if (which == 0) RD_REQ = 0; else RD_REQ2 = 0;
    n = 0;
    do begin @(negedge CLK); n++; end
    while (((which == 0) ? RD_ACK : RD_ACK2) !== 1'b0 && n < 20);
    if (n >= 20) chk("ack_fall_timeout", 0, 1);
  endtask

  logic [CNTW-1:0] d;
  int acks;

  initial begin
    RSTB = 0;
    repeat (2) @(negedge CLK);
    chk("reset_qn", 32'(QN), 32'hF);
    chk("reset_ack", 32'(RD_ACK), 0);
    RSTB = 1;
    @(negedge CLK);
    chk("post_reset_qn", 32'(QN), 32'hF);
    rd(0, 3, d); chk("reset_cnt3", 32'(d), 0);

    // AOI
    EN = 1; IN = {5'b0, 5'b0, 5'b0, 5'b00011};
    @(negedge CLK); chk("aoi_qn", 32'(QN), 32'hE);
    rd(0, 0, d); chk("aoi_cnt0", 32'(d), 1);
    IN = {5'b0, 5'b0, 5'b0, 5'b10000};
    @(negedge CLK); chk("aoi_single_qn", 32'(QN), 32'hE);
    rd(0, 0, d); chk("aoi_cnt0_hold", 32'(d), 1);

    // OAI: ch0 also flips since its groups are all zero
    MODE = 1; IN = {5'b0, 5'b0, 5'b10101, 5'b10000};
    @(negedge CLK); chk("oai_qn1_lo", 32'(QN[1]), 0);
    IN = {5'b0, 5'b0, 5'b00101, 5'b10000};
    @(negedge CLK); chk("oai_qn1_hi", 32'(QN[1]), 1);
    rd(0, 1, d); chk("oai_cnt1", 32'(d), 2);
    rd(0, 0, d); chk("oai_cnt0", 32'(d), 2);

    // Enable hold
    EN = 0;
    for (int i = 0; i < 10; i++) begin
      IN = CH*W'($urandom); MODE = 1'($urandom);
      @(negedge CLK); chk("hold_qn", 32'(QN), 32'hF);
    end
    rd(0, 1, d); chk("hold_cnt1", 32'(d), 2);

    // Saturation on ch2
    EN = 1; MODE = 0;
    for (int i = 0; i < 20; i++) begin
      IN = {5'b0, (i % 2 == 0) ? 5'b00011 : 5'b00000, 5'b0, 5'b10000};
      @(negedge CLK);
    end
    rd(0, 2, d); chk("sat_cnt2", 32'(d), 15);

    // CLR beats a coincident toggle
    IN = {5'b0, 5'b00011, 5'b0, 5'b10000}; CLR = 1;
    @(negedge CLK); CLR = 0; EN = 0;
    rd(0, 2, d); chk("clr_cnt2", 32'(d), 0);
    rd(0, 0, d); chk("clr_cnt0", 32'(d), 0);

    // Handshake with the counter moving underneath
    EN = 1; RD_SEL = 2; acks = 0;
    for (int i = 0; i < 10; i++) begin
      RD_REQ = (i < 5);
      IN = {5'b0, (i % 2 == 0) ? 5'b00000 : 5'b00011, 5'b0, 5'b10000};
      @(negedge CLK);
      if (RD_ACK) begin acks++; chk("hs_data_stable", 32'(RD_DATA), 0); end
    end
    chk("hs_ack_cycles", 32'(acks), 5);
    EN = 0;
    rd(0, 2, d); chk("hs_cnt2", 32'(d), 10);
    rd(0, 2, d); chk("rereq_cnt2", 32'(d), 10);

    // Out-of-range select on the CH=3 instance
    rd(1, 3, d); chk("oor_data", 32'(d), 0);
    rd(1, 2, d); chk("dut2_cnt2", 32'(d), 10);

    // Reset in the middle of a read while ch3 toggles
    EN = 1;
    for (int i = 0; i < 3; i++) begin
      IN = {(i % 2 == 0) ? 5'b00011 : 5'b00000, 5'b0, 5'b0, 5'b10000};
      @(negedge CLK);
    end
    RD_SEL = 3; RD_REQ = 1;
    for (int i = 0; i < 3; i++) begin
      IN = {(i % 2 == 0) ? 5'b00011 : 5'b00000, 5'b0, 5'b0, 5'b10000};
      @(negedge CLK);
    end
    chk("mid_ack", 32'(RD_ACK), 1);
    chk("mid_data", 32'(RD_DATA), 3);
    #2 RSTB = 0;
    #1;
    chk("rst_ack", 32'(RD_ACK), 0);
    chk("rst_data", 32'(RD_DATA), 0);
    chk("rst_qn", 32'(QN), 32'hF);
    @(negedge CLK); RSTB = 1;
    @(negedge CLK);
    chk("rerd_ack", 32'(RD_ACK), 1);
    chk("rerd_data", 32'(RD_DATA), 0);
    RD_REQ = 0; EN = 0;
    repeat (3) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
